// File: rtl/pokey_clk_sched.sv
// Clock scheduler for the four POKEY audio divider chains: base prescalers, channel enables, reloads, STIMER hold.
// Define STIMER_PRESCALE_RST_EN to make STIMER also clear both base prescalers.
module pokey_clk_sched #(
  parameter int DIV64 = 28,
  parameter int DIV15 = 114,
  parameter int PW    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic [7:0] audctl,
  input  logic       stimer,
  input  logic [3:0] ch_done,
  output logic [3:0] ch_clk,
  output logic [3:0] ch_rst,
  output logic       base_tick
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [PW-1:0] P64_LAST = PW'(DIV64 - 1);
  localparam logic [PW-1:0] P15_LAST = PW'(DIV15 - 1);
  localparam logic [PW-1:0] P_ZERO   = PW'(0);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  state_t        state_r;
  logic [PW-1:0] p64_r;
  logic [PW-1:0] p15_r;
  logic          tick64_s;
  logic          tick15_s;
  logic          base_s;
  logic [3:0]    src_s;
  logic [3:0]    reld_s;
  logic          unused_audctl_s;

  // Base ticks, per-channel count sources and underflow reloads for this cycle.
  always_comb begin
    tick64_s  = enp && (p64_r == P64_LAST);
    tick15_s  = enp && (p15_r == P15_LAST);
    base_s    = audctl[0] ? tick15_s : tick64_s;
    src_s[0]  = audctl[6] ? enp : base_s;
    src_s[1]  = audctl[4] ? (enp && ch_done[0]) : base_s;
    src_s[2]  = audctl[5] ? enp : base_s;
    src_s[3]  = audctl[3] ? (enp && ch_done[2]) : base_s;
    // A joined pair reloads as a unit, only when its high channel underflows.
    reld_s[0] = enp && (audctl[4] ? ch_done[1] : ch_done[0]);
    reld_s[1] = enp && ch_done[1];
    reld_s[2] = enp && (audctl[3] ? ch_done[3] : ch_done[2]);
    reld_s[3] = enp && ch_done[3];
    unused_audctl_s = ^{audctl[7], audctl[2:1]};
  end

  // Free-running base prescalers, stepped once per enp strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      p64_r <= P_ZERO;
      p15_r <= P_ZERO;
`ifdef STIMER_PRESCALE_RST_EN
    end else if (stimer) begin
      p64_r <= P_ZERO;
      p15_r <= P_ZERO;
`endif
    end else if (enp) begin
      p64_r <= (p64_r == P64_LAST) ? P_ZERO : (p64_r + P_ONE);
      p15_r <= (p15_r == P15_LAST) ? P_ZERO : (p15_r + P_ONE);
    end else begin
      p64_r <= p64_r;
      p15_r <= p15_r;
    end
  end

  // Selected base tick, delayed one clock to line up with the channel enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_tick <= 1'b0;
    end else begin
      base_tick <= base_s;
    end
  end

  // RUN/HOLD scheduler: STIMER holds every R high until an enp has been sampled in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      ch_clk  <= 4'h0;
      ch_rst  <= 4'h0;
    end else begin
      case (state_r)
        RUN: begin
          if (stimer) begin
            state_r <= HOLD;
            ch_clk  <= 4'h0;
            ch_rst  <= 4'hF;
          end else begin
            state_r <= RUN;
            ch_clk  <= src_s & ~reld_s;
            ch_rst  <= reld_s;
          end
        end
        HOLD: begin
          ch_clk  <= 4'h0;
          ch_rst  <= 4'hF;
          state_r <= (enp && !stimer) ? RUN : HOLD;
        end
        default: begin
          state_r <= RUN;
          ch_clk  <= 4'h0;
          ch_rst  <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pokey_clk_sched.sv
// Directed bench for pokey_clk_sched: stimulus pushes expected {base_tick, ch_clk, ch_rst} into a scoreboard.
module tb_pokey_clk_sched;

  logic       clk;
  logic       reset;
  logic       enp;
  logic [7:0] audctl;
  logic       stimer;
  logic [3:0] ch_done;
  logic [3:0] ch_clk;
  logic [3:0] ch_rst;
  logic       base_tick;

  logic [8:0] ex_q[$];
  logic [8:0] mk_q[$];
  string      nm_q[$];
  int         checks;
  int         errors;
  logic       done_stim;

  localparam logic [8:0] FULL = 9'h1FF;
  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] TICK = 9'h1F0;
  localparam logic [8:0] HELD = 9'h00F;

`ifdef STIMER_PRESCALE_RST_EN
  localparam int T5_TGT = 28;
`else
  localparam int T5_TGT = 11;
`endif

  pokey_clk_sched dut (
    .clk      (clk),
    .reset    (reset),
    .enp      (enp),
    .audctl   (audctl),
    .stimer   (stimer),
    .ch_done  (ch_done),
    .ch_clk   (ch_clk),
    .ch_rst   (ch_rst),
    .base_tick(base_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply one cycle of inputs; the output after this edge is what ex describes.
  task automatic step(input logic e, input logic s, input logic [3:0] d,
                      input logic [8:0] ex, input logic [8:0] mk, input string nm);
    enp     = e;
    stimer  = s;
    ch_done = d;
    @(posedge clk);
    ex_q.push_back(ex);
    mk_q.push_back(mk);
    nm_q.push_back(nm);
    #1;
  endtask

  task automatic enp_cycle(input logic [3:0] d, input logic [8:0] ex,
                           input logic [8:0] mk, input string nm);
    step(1'b1, 1'b0, d, ex, mk, nm);
    step(1'b0, 1'b0, 4'h0, NONE, FULL, {nm, "_idle"});
  endtask

  // Monitor: compares every scoreboard entry against the outputs at the following falling edge.
  initial begin
    logic [8:0] ex;
    logic [8:0] mk;
    logic [8:0] act;
    string      nm;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      if (ex_q.size() > 0) begin
        ex  = ex_q.pop_front();
        mk  = mk_q.pop_front();
        nm  = nm_q.pop_front();
        act = {base_tick, ch_clk, ch_rst};
        if (mk != 9'h000) begin
          checks = checks + 1;
          if ((act & mk) !== (ex & mk)) begin
            errors = errors + 1;
            $display("FAIL %s: got base_tick=%b ch_clk=%b ch_rst=%b, expected base_tick=%b ch_clk=%b ch_rst=%b (mask %b)",
                     nm, act[8], act[7:4], act[3:0], ex[8], ex[7:4], ex[3:0], mk);
          end
        end
      end
      if (done_stim && ex_q.size() == 0) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    done_stim = 1'b0;
    reset     = 1'b1;
    audctl    = 8'h00;
    enp       = 1'b0;
    stimer    = 1'b0;
    ch_done   = 4'h0;

    // Power-on reset, then run with every channel underflowing to get activity.
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "por");
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      enp_cycle(4'hF, HELD, FULL, "warm_reload");
    end

    // Reset mid-count with underflows pending.
    reset = 1'b1;
    step(1'b1, 1'b0, 4'hF, NONE, FULL, "reset_1");
    step(1'b0, 1'b0, 4'hF, NONE, FULL, "reset_2");
    step(1'b1, 1'b0, 4'hF, NONE, FULL, "reset_3");
    checks = checks + 5;
    if (ch_clk !== 4'h0) begin
      errors = errors + 1;
      $display("FAIL reset_direct: ch_clk=%b", ch_clk);
    end
    if (ch_rst !== 4'h0) begin
      errors = errors + 1;
      $display("FAIL reset_direct: ch_rst=%b", ch_rst);
    end
    if (base_tick !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_direct: base_tick=%b", base_tick);
    end
    if (dut.p64_r !== 7'd0) begin
      errors = errors + 1;
      $display("FAIL reset_direct: p64=%0d", dut.p64_r);
    end
    if (dut.p15_r !== 7'd0) begin
      errors = errors + 1;
      $display("FAIL reset_direct: p15=%0d", dut.p15_r);
    end
    reset = 1'b0;

    // 64 kHz base: a tick on every 28th enp, also the proof that reset cleared p64.
    for (int k = 1; k <= 280; k++) begin
      enp_cycle(4'h0, (k % 28 == 0) ? TICK : NONE, FULL, "base64");
    end

    // 15 kHz base from a fresh reset.
    reset = 1'b1;
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "reset_t2b");
    reset  = 1'b0;
    audctl = 8'h01;
    for (int k = 1; k <= 228; k++) begin
      enp_cycle(4'h0, (k % 114 == 0) ? TICK : NONE, FULL, "base15");
    end

    // ch0 on 1.79 MHz joined into ch1; ch1 underflow reloads the pair.
    reset = 1'b1;
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "reset_t3");
    reset  = 1'b0;
    audctl = 8'h50;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10) begin
        enp_cycle(4'h2, 9'h003, 9'h10F, "join_reload");
      end else if (k % 4 == 0) begin
        enp_cycle(4'h1, 9'h030, FULL, "join_carry");
      end else begin
        enp_cycle(4'h0, 9'h010, FULL, "join_fast");
      end
    end

    // STIMER coincident with enp, then STIMER again inside HOLD.
    step(1'b1, 1'b1, 4'h0, HELD, FULL, "stim_enp");
    step(1'b0, 1'b0, 4'h0, HELD, FULL, "hold_1");
    step(1'b0, 1'b1, 4'h0, HELD, FULL, "stim_in_hold");
    step(1'b1, 1'b1, 4'h0, HELD, FULL, "stim_enp_in_hold");
    step(1'b0, 1'b0, 4'h0, HELD, FULL, "hold_extended");
    step(1'b1, 1'b0, 4'h0, HELD, FULL, "hold_release");
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "rst_deassert");
    step(1'b1, 1'b0, 4'h0, 9'h010, FULL, "run_resume");
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "run_resume_idle");

    // STIMER at p64 = 17: first base tick position depends on prescaler clearing.
    reset = 1'b1;
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "reset_t5");
    reset  = 1'b0;
    audctl = 8'h00;
    for (int k = 1; k <= 17; k++) begin
      enp_cycle(4'h0, NONE, FULL, "t5_pre");
    end
    step(1'b0, 1'b1, 4'h0, HELD, FULL, "t5_stimer");
    step(1'b0, 1'b0, 4'h0, HELD, FULL, "t5_hold");
    step(1'b1, 1'b0, 4'h0, HELD, FULL, "t5_release");
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "t5_release_idle");
    for (int k = 2; k <= 30; k++) begin
      enp_cycle(4'h0, (k == T5_TGT) ? TICK : NONE, FULL, "t5_after_release");
    end

    // audctl 00 -> 01 between enp 27 and 28: the due 64 kHz tick must not appear.
    reset = 1'b1;
    step(1'b0, 1'b0, 4'h0, NONE, FULL, "reset_t6");
    reset  = 1'b0;
    audctl = 8'h00;
    for (int k = 1; k <= 27; k++) begin
      step(1'b1, 1'b0, 4'h0, NONE, FULL, "t6_pre");
      if (k == 27) begin
        audctl = 8'h01;
      end
      step(1'b0, 1'b0, 4'h0, NONE, FULL, "t6_pre_idle");
    end
    for (int k = 28; k <= 116; k++) begin
      enp_cycle(4'h0, (k == 114) ? TICK : NONE, FULL, (k == 28) ? "t6_no_stale64" : "t6_base15");
    end

    done_stim = 1'b1;
  end

endmodule
